// File: rtl/viterbi_branch_metric_pipe.sv
// Two-stage branch-metric unit for the rate-1/2 Viterbi front end.
// Stage 1 converts sign-magnitude soft values; stage 2 forms the four metrics with optional clipping.
module viterbi_branch_metric_pipe #(
  parameter int W    = 8,
  parameter int OW   = 10,
  parameter int IDXW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_r1,
  input  logic [W-1:0]    in_r2,
  input  logic            in_erase1,
  input  logic            in_erase2,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_d1,
  output logic [OW-1:0]   out_d2,
  output logic [OW-1:0]   out_d3,
  output logic [OW-1:0]   out_d4,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_sat
);

  localparam int W2 = W + 2;
  localparam int SW = (OW > W2) ? OW : W2;
  // Symmetric clip bound 2^(OW-1)-1; never reachable when OW >= W+2.
  localparam logic signed [SW-1:0] MAXV = SW'({(SW-1){1'b1}}) >> (SW - OW);
  localparam logic signed [SW-1:0] MINV = -MAXV;

  function automatic logic signed [W:0] to_tc(input logic [W-1:0] r, input logic erase);
    logic signed [W:0] m;
    m = signed'({1'b0, r[W-2:0], 1'b0});
    if (erase) return '0;
    return r[W-1] ? -m : m;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OW:0] clip(input logic signed [W2-1:0] x);
    logic signed [SW-1:0] e;
    e = SW'(x);
    if (e > MAXV) return {1'b1, MAXV[OW-1:0]};
    if (e < MINV) return {1'b1, MINV[OW-1:0]};
    return {1'b0, e[OW-1:0]};
  endfunction

  logic                   v1, last1;
  logic signed [W:0]      a1, b1;
  logic [IDXW-1:0]        cnt, idx1;
  logic                   en1, en2;
  logic signed [W2-1:0]   sum, dif;
  logic [OW:0]            c1, c2, c3, c4;

  always_comb begin
    en2      = !out_valid || out_ready;
    en1      = !v1 || en2;
    in_ready = en1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      idx1  <= '0;
      last1 <= 1'b0;
      cnt   <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1    <= to_tc(in_r1, in_erase1);
        b1    <= to_tc(in_r2, in_erase2);
        idx1  <= cnt;
        last1 <= in_last;
        cnt   <= in_last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sum = W2'(a1) + W2'(b1);
    dif = W2'(a1) - W2'(b1);
    c1  = clip(-sum);
    c2  = clip(sum);
    c3  = clip(dif);
    c4  = clip(-dif);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_d3    <= '0;
      out_d4    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (en2) begin
      out_valid <= v1;
      if (v1) begin
        out_d1   <= c1[OW-1:0];
        out_d2   <= c2[OW-1:0];
        out_d3   <= c3[OW-1:0];
        out_d4   <= c4[OW-1:0];
        out_idx  <= idx1;
        out_last <= last1;
        out_sat  <= c1[OW] | c2[OW] | c3[OW] | c4[OW];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_branch_metric_pipe.sv
// Bench for viterbi_branch_metric_pipe: directed table, framing/backpressure/reset sequences,
// and a randomized stream scored against an arithmetic model (OW=10 and OW=8 instances).
module tb_viterbi_branch_metric_pipe;
  localparam int W = 8, OW = 10, IDXW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, in_erase1, in_erase2, in_last, out_valid, out_ready, out_last, out_sat;
  logic [W-1:0] in_r1, in_r2;
  logic [OW-1:0] out_d1, out_d2, out_d3, out_d4;
  logic [IDXW-1:0] out_idx;
  logic o8_ready, o8_valid, o8_last, o8_sat;
  logic [7:0] o8_d1, o8_d2, o8_d3, o8_d4;
  logic [IDXW-1:0] o8_idx;

  viterbi_branch_metric_pipe #(.W(W), .OW(OW), .IDXW(IDXW)) u10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_r1(in_r1), .in_r2(in_r2),
    .in_erase1(in_erase1), .in_erase2(in_erase2), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3), .out_d4(out_d4),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat));

  viterbi_branch_metric_pipe #(.W(W), .OW(8), .IDXW(IDXW)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o8_ready), .in_r1(in_r1), .in_r2(in_r2),
    .in_erase1(in_erase1), .in_erase2(in_erase2), .in_last(in_last), .out_valid(o8_valid),
    .out_ready(out_ready), .out_d1(o8_d1), .out_d2(o8_d2), .out_d3(o8_d3), .out_d4(o8_d4),
    .out_idx(o8_idx), .out_last(o8_last), .out_sat(o8_sat));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r1, r2;
    logic e1, e2;
    int d1, d2, d3, d4; logic s10;
    int q1, q2, q3, q4; logic s8;
  } vec_t;

  typedef struct {
    int d1, d2, d3, d4, q1, q2, q3, q4, idx;
    logic s10, s8, last;
  } exp_t;

  exp_t q[$];
  int mcnt = 0;

  function automatic int dbl(input logic [7:0] r, input logic e);
    int m;
    m = int'(r[6:0]);
    if (e) return 0;
    return r[7] ? -2 * m : 2 * m;
  endfunction

  function automatic int clipv(input int x, input int ow, inout logic s);
    int m;
    m = (1 << (ow - 1)) - 1;
    if (x > m) begin s = 1'b1; return m; end
    if (x < -m) begin s = 1'b1; return -m; end
    return x;
  endfunction

  function automatic exp_t model(input logic [7:0] r1, r2, input logic e1, e2);
    exp_t e;
    int a, b;
    a = dbl(r1, e1);
    b = dbl(r2, e2);
    e.s10 = 1'b0; e.s8 = 1'b0;
    e.d1 = clipv(-(a + b), 10, e.s10); e.d2 = clipv(a + b, 10, e.s10);
    e.d3 = clipv(a - b, 10, e.s10);    e.d4 = clipv(b - a, 10, e.s10);
    e.q1 = clipv(-(a + b), 8, e.s8);   e.q2 = clipv(a + b, 8, e.s8);
    e.q3 = clipv(a - b, 8, e.s8);      e.q4 = clipv(b - a, 8, e.s8);
    e.idx = 0; e.last = 1'b0;
    return e;
  endfunction

  logic hv = 1'b0, saw_stall = 1'b0;
  logic [OW-1:0] h1, h2, h3, h4;
  logic [IDXW-1:0] hidx;

  // Called once per cycle at negedge: scores the handshakes the next posedge will perform.
  task automatic acct();
    exp_t e;
    if (hv) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_d1", int'(out_d1), int'(h1)); chk("hold_d2", int'(out_d2), int'(h2));
      chk("hold_d3", int'(out_d3), int'(h3)); chk("hold_d4", int'(out_d4), int'(h4));
      chk("hold_idx", int'(out_idx), int'(hidx));
    end
    hv = out_valid && !out_ready;
    h1 = out_d1; h2 = out_d2; h3 = out_d3; h4 = out_d4; hidx = out_idx;
    if (in_valid && !in_ready) saw_stall = 1'b1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("idx", int'(out_idx), e.idx);   chk("last", int'(out_last), int'(e.last));
        chk("d1", int'($signed(out_d1)), e.d1); chk("d2", int'($signed(out_d2)), e.d2);
        chk("d3", int'($signed(out_d3)), e.d3); chk("d4", int'($signed(out_d4)), e.d4);
        chk("sat", int'(out_sat), int'(e.s10));
        chk("o8_d1", int'($signed(o8_d1)), e.q1); chk("o8_d2", int'($signed(o8_d2)), e.q2);
        chk("o8_d3", int'($signed(o8_d3)), e.q3); chk("o8_d4", int'($signed(o8_d4)), e.q4);
        chk("o8_sat", int'(o8_sat), int'(e.s8));
      end
    end
    if (in_valid && in_ready) begin
      e = model(in_r1, in_r2, in_erase1, in_erase2);
      e.idx = mcnt;
      e.last = in_last;
      q.push_back(e);
      mcnt = in_last ? 0 : (mcnt + 1) % (1 << IDXW);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] r1, r2, input logic e1, e2, last, ordy);
    in_valid = v; in_r1 = r1; in_r2 = r2; in_erase1 = e1; in_erase2 = e2; in_last = last;
    out_ready = ordy;
    @(negedge clk);
    acct();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++)
      cycle(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    chk(name, q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); mcnt = 0; hv = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  vec_t tv[9];

  initial begin
    tv[0] = '{8'h05, 8'h03, 1'b0, 1'b0,  -16,   16,    4,   -4, 1'b0,  -16,   16,    4,   -4, 1'b0};
    tv[1] = '{8'h85, 8'h03, 1'b0, 1'b0,    4,   -4,  -16,   16, 1'b0,    4,   -4,  -16,   16, 1'b0};
    tv[2] = '{8'h80, 8'h00, 1'b0, 1'b0,    0,    0,    0,    0, 1'b0,    0,    0,    0,    0, 1'b0};
    tv[3] = '{8'h7F, 8'h7F, 1'b0, 1'b0, -508,  508,    0,    0, 1'b0, -127,  127,    0,    0, 1'b1};
    tv[4] = '{8'hFF, 8'h7F, 1'b0, 1'b0,    0,    0, -508,  508, 1'b0,    0,    0, -127,  127, 1'b1};
    tv[5] = '{8'h7F, 8'h7F, 1'b1, 1'b1,    0,    0,    0,    0, 1'b0,    0,    0,    0,    0, 1'b0};
    tv[6] = '{8'h85, 8'h03, 1'b1, 1'b0,   -6,    6,   -6,    6, 1'b0,   -6,    6,   -6,    6, 1'b0};
    tv[7] = '{8'h00, 8'hFF, 1'b0, 1'b0,  254, -254,  254, -254, 1'b0,  127, -127,  127, -127, 1'b1};
    tv[8] = '{8'h40, 8'hC0, 1'b0, 1'b0,    0,    0,  256, -256, 1'b0,    0,    0,  127, -127, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_r1 = '0; in_r2 = '0;
    in_erase1 = 1'b0; in_erase2 = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0); chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_d1", int'(out_d1), 0);           chk("reset_d2", int'(out_d2), 0);
    chk("reset_idx", int'(out_idx), 0);         chk("reset_last", int'(out_last), 0);
    chk("reset_sat", int'(out_sat), 0);
    @(posedge clk); #1;

    // Directed table: one beat at a time, exact two-cycle latency.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_r1 = tv[i].r1; in_r2 = tv[i].r2;
      in_erase1 = tv[i].e1; in_erase2 = tv[i].e2; in_last = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_early_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_idx", int'(out_idx), i);
      chk("tbl_d1", int'($signed(out_d1)), tv[i].d1); chk("tbl_d2", int'($signed(out_d2)), tv[i].d2);
      chk("tbl_d3", int'($signed(out_d3)), tv[i].d3); chk("tbl_d4", int'($signed(out_d4)), tv[i].d4);
      chk("tbl_sat", int'(out_sat), int'(tv[i].s10));
      chk("tbl8_d1", int'($signed(o8_d1)), tv[i].q1); chk("tbl8_d2", int'($signed(o8_d2)), tv[i].q2);
      chk("tbl8_d3", int'($signed(o8_d3)), tv[i].q3); chk("tbl8_d4", int'($signed(o8_d4)), tv[i].q4);
      chk("tbl8_sat", int'(o8_sat), int'(tv[i].s8));
      @(posedge clk); #1;
    end

    // Framing: last on beat 4, erase1 on beat 2.
    do_reset();
    for (int i = 1; i <= 5; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), i == 2, 1'b0, i == 4, 1'b1);
    drain("frame_drain");

    // Backpressure: 8 beats, out_ready low for 3 cycles mid-stream.
    saw_stall = 1'b0;
    for (int i = 0, n = 0; i < 30 && n < 8; i++) begin
      in_valid = 1'b1;
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, !(i >= 3 && i <= 5));
      if (q.size() != 0 || in_ready) n = 8 - (8 - n);
      n = n + 0;
      if (in_valid && in_ready) n++;
    end
    chk("bp_in_ready_fell", int'(saw_stall), 1);
    drain("bp_drain");

    // Reset with two beats in flight.
    cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); mcnt = 0; hv = 1'b0;
    @(negedge clk);
    chk("rst_flush_valid", int'(out_valid), 0);
    chk("rst_flush_ready", int'(in_ready), 1);
    chk("rst_flush_o8", int'(o8_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("rst_drain");

    // Randomized stream with random valid, backpressure, erasures and frame ends.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    drain("rand_drain");

    // Index counter: last at max tags 4095 then 0; later a silent wrap without last.
    do_reset();
    for (int i = 0; i < 4095; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4098; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    drain("wrap_drain");
    chk("wrap_model_cnt", mcnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_branch_metric_pipe.md
Name: viterbi_branch_metric_pipe

Overview:
Parametrised, pipelined branch-metric unit for the rate-1/2 Viterbi decoder front end. It accepts one received symbol pair (R1, R2) per beat as sign-magnitude soft values. It produces the four branch metrics d1=-2R1-2R2, d2=+2R1+2R2, d3=+2R1-2R2 and d4=-2R1+2R2 in two's complement, with optional saturation. The block sits between the demapper/depuncturer and the ACS stage, with a valid/ready handshake on both sides and frame/symbol-index tagging.

Parameters:
W, 8, input soft-value width, sign-magnitude (bit W-1 = sign, bits W-2:0 = magnitude)
OW, 10, output metric width, two's complement; OW >= W+2 never saturates
IDXW, 12, symbol-index counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_r1  in  W  received soft value R1, sign-magnitude
in_r2  in  W  received soft value R2, sign-magnitude
in_erase1  in  1  R1 punctured; treat R1 as 0
in_erase2  in  1  R2 punctured; treat R2 as 0
in_last  in  1  last symbol of frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_d1, out_d2, out_d3, out_d4  out  OW each  branch metrics, two's complement
out_idx  out  IDXW  symbol index within frame of this beat
out_last  out  1  in_last carried with beat
out_sat  out  1  at least one of the four metrics of this beat was clipped

Behaviour:
- Reset (rst=1 at clk edge): both stage valids, out_valid, out_last and out_sat go to 0. out_d1..d4 go to 0. out_idx and the index counter go to 0. in_ready reads 1 in the cycle after reset releases. Reset mid-frame discards in-flight beats; no partial output is produced.
- Accept: a beat is transferred when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Stage 1 (registered):
  - Convert each input to two's complement, W+1 bits, already doubled: value = (sign ? -mag : +mag) << 1.
  - Negative zero (sign=1, mag=0) yields 0.
  - Erase forces the value to 0, regardless of the data.
  - Capture the current index counter value and in_last.
- Stage 2 (registered):
  - Compute d2=A+B, d1=-(A+B), d3=A-B, d4=B-A at W+2 bits. A and B are the doubled values from stage 1.
  - If OW < W+2, clamp each metric to [-(2^(OW-1)-1), +(2^(OW-1)-1)], a symmetric range that never uses the most-negative code. out_sat = OR of the clip events.
  - If OW >= W+2, sign-extend the metrics and hold out_sat at 0.
- Latency: exactly 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stall: en2 = !v2 || out_ready; en1 = !v1 || en2; in_ready = en1. A stage holds its contents while its enable is low. Outputs stay stable while out_valid && !out_ready. No beat is lost or duplicated.
- Index counter:
  - Increments on every accepted beat.
  - Resets to 0 on an accepted beat carrying in_last, so the next frame starts at 0.
  - Wraps from 2^IDXW-1 to 0 with no flag.
  - The first beat after reset has idx 0.
- Simultaneous events:
  - A stage-2 output transfer and a new stage-2 load in the same cycle both occur.
  - in_last with index at max: the beat is tagged max, then the counter goes to 0.
  - Erase on both inputs: all metrics are 0 and out_sat=0.
- Data on in_r1/in_r2 is ignored when in_valid=0.

Test Plan:
1. W=8, OW=10, in_r1=0x05, in_r2=0x03 -> two cycles later d1=0x3F0 (-16), d2=0x010 (16), d3=0x004 (4), d4=0x3FC (-4), idx=0, sat=0.
2. in_r1=0x85 (-5), in_r2=0x03 -> d1=4, d2=-4, d3=-16, d4=16. Also in_r1=0x80, in_r2=0x00 -> all metrics 0.
3. Saturation, OW=8: in_r1=in_r2=0x7F -> d2=+127, d1=-127, d3=0, d4=0, out_sat=1. Same input with OW=10 -> d2=508, d1=-508, out_sat=0.
4. Erase and framing: 5 beats with in_last on beat 4, in_erase1=1 on beat 2 -> out_idx 0,1,2,3,0. out_last set on the 4th beat only. Beat 2 metrics use R1=0.
5. Backpressure: stream 8 beats, drop out_ready for 3 cycles mid-stream -> in_ready falls once both stages are full. Outputs are held stable, and all 8 beats arrive in order with correct metrics.
6. Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, no stale beats emitted, next accepted beat has idx 0.
